// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: command sequencer between the SPI serdes and the control
// register bus. Each received packet becomes one bus read or write (or a
// NOP), and the response packet is loaded into the serdes for shift-out
// during the next SPI packet. Burst access uses an auto-incrementing
// pointer, every bus access is bounded by a timeout, and timeouts and
// dropped packets are reported in the response status byte.
module spi_reg_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16    // legal range 1..255
) (
    input  logic                    clk,
    input  logic                    rst,
    // serdes side
    input  logic [DATA_WIDTH+7:0]   rx_data,
    input  logic                    rx_valid,
    output logic [DATA_WIDTH+7:0]   tx_data,
    output logic                    tx_load,
    // register bus side
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [5:0]              bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    bus_ack,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    // status
    output logic                    busy
);

    localparam int         PKT_W    = DATA_WIDTH + 8;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [5:0] NOP_ADDR = 6'h3F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [5:0]              ptr_q, ptr_d;
    logic                    we_q, we_d;
    logic [5:0]              addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    ov_q, ov_d;
    logic [PKT_W-1:0]        tx_data_q, tx_data_d;
    logic                    tx_load_q, tx_load_d;
    logic                    bus_req_q, bus_req_d;
    logic                    busy_q, busy_d;

    // Header decode of the incoming packet.
    logic [7:0]              hdr;
    logic                    hdr_w;
    logic                    hdr_p;
    logic [5:0]              hdr_addr;
    logic                    hdr_nop;

    assign hdr      = rx_data[PKT_W-1:DATA_WIDTH];
    assign hdr_w    = hdr[7];
    assign hdr_p    = hdr[6];
    assign hdr_addr = hdr_p ? ptr_q : hdr[5:0];
    // Only an explicit-address read of 0x3F is a NOP; a pointer read that
    // happens to land on 0x3F is a real access.
    assign hdr_nop  = !hdr_w && !hdr_p && (hdr[5:0] == NOP_ADDR);

    // Response assembly helpers, driven from the next-state logic.
    logic                    load;
    logic                    resp_to;
    logic [4:0]              resp_addr;
    logic [DATA_WIDTH-1:0]   resp_data;
    logic                    ov_set;

    // Next-state, datapath and output decode for the sequencer.
    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        ov_d      = ov_q;
        tx_data_d = tx_data_q;
        load      = 1'b0;
        resp_to   = 1'b0;
        resp_addr = addr_q[4:0];
        resp_data = '0;

        // A packet arriving outside IDLE (including the RESP cycle) is lost.
        ov_set = rx_valid && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (hdr_nop) begin
                        // No bus access: the bus registers and pointer keep
                        // their values and the response is built right away.
                        state_d   = RESP;
                        load      = 1'b1;
                        resp_addr = NOP_ADDR[4:0];
                    end else begin
                        state_d = ACCESS;
                        we_d    = hdr_w;
                        addr_d  = hdr_addr;
                        wdata_d = rx_data[DATA_WIDTH-1:0];
                        cnt_d   = '0;
                        ptr_d   = hdr_addr + 6'd1;
                    end
                end
            end

            ACCESS: begin
                // Ack is tested first so an ack on the expiry cycle wins.
                if (bus_ack) begin
                    state_d   = RESP;
                    load      = 1'b1;
                    resp_data = we_q ? wdata_q : bus_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RESP;
                    load      = 1'b1;
                    resp_to   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // TO is raised and reported on the same edge, so it needs no storage
        // of its own; OV is sticky until it is placed into a response, and an
        // overrun in the loading cycle itself is reported immediately.
        if (load) begin
            tx_data_d = {1'b1, resp_to, ov_q | ov_set, resp_addr, resp_data};
            ov_d      = 1'b0;
        end else if (ov_set) begin
            ov_d = 1'b1;
        end

        // Outputs are registered from the next state so nothing on the
        // serdes or bus inputs reaches an output combinationally.
        tx_load_d = load;
        bus_req_d = (state_d == ACCESS);
        busy_d    = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values regardless of order.
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            ov_q      <= 1'b0;
            tx_data_q <= '0;
            tx_load_q <= 1'b0;
            bus_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            ov_q      <= ov_d;
            tx_data_q <= tx_data_d;
            tx_load_q <= tx_load_d;
            bus_req_q <= bus_req_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_load   = tx_load_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl. Expected response packets are
// queued when a command is sent and popped when tx_load is observed.
module tb_spi_reg_ctrl;

    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic            clk;
    logic            rst;
    logic [DW+7:0]   rx_data;
    logic            rx_valid;
    logic [DW+7:0]   tx_data;
    logic            tx_load;
    logic            bus_req;
    logic            bus_we;
    logic [5:0]      bus_addr;
    logic [DW-1:0]   bus_wdata;
    logic            bus_ack;
    logic [DW-1:0]   bus_rdata;
    logic            busy;

    spi_reg_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW+7:0] exp_q[$];

    // Bus responder: acks in the ack_delay-th cycle of a request (0 = never).
    int            ack_delay  = 0;
    logic [DW-1:0] rdata_val  = '0;
    int            req_cycles = 0;

    always @(negedge clk) begin
        if (bus_req === 1'b1) begin
            req_cycles = req_cycles + 1;
            if (ack_delay > 0 && req_cycles == ack_delay) begin
                bus_ack   = 1'b1;
                bus_rdata = rdata_val;
            end else begin
                bus_ack = 1'b0;
            end
        end else begin
            req_cycles = 0;
            bus_ack    = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive a one-cycle rx_valid pulse; call and return on a negedge.
    task automatic send(input logic [7:0] hdr, input logic [DW-1:0] data);
        rx_data  = {hdr, data};
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    // Wait (bounded) for tx_load, then check latency, request length and data.
    task automatic wait_resp(input string name, input int lat0, input int req0,
                             input int exp_lat, input int exp_req);
        int lat;
        int reqs;
        logic [DW+7:0] exp;
        lat  = lat0;
        reqs = req0;
        while (tx_load !== 1'b1 && lat < lat0 + 300) begin
            if (bus_req === 1'b1) reqs++;
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (tx_load !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: tx_load never seen, required within %0d cycles", name, exp_lat);
            return;
        end
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, exp_lat);
        end
        n_checks++;
        if (reqs !== exp_req) begin
            n_fail++;
            $display("FAIL %s bus_req length: got %0d cycles, required %0d", name, reqs, exp_req);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: unexpected response %h", name, tx_data);
        end else begin
            exp = exp_q.pop_front();
            if (tx_data !== exp) begin
                n_fail++;
                $display("FAIL %s tx_data: got %h, required %h", name, tx_data, exp);
            end
        end
    endtask

    // Full transaction from IDLE back to IDLE.
    task automatic xact(input string name, input logic [7:0] hdr, input logic [DW-1:0] data,
                        input int dly, input logic [DW-1:0] rd, input logic [5:0] exp_addr,
                        input logic [DW+7:0] exp_resp, input int exp_lat, input int exp_req);
        ack_delay = dly;
        rdata_val = rd;
        exp_q.push_back(exp_resp);
        send(hdr, data);
        if (exp_req > 0) begin
            n_checks++;
            if (bus_addr !== exp_addr || bus_we !== hdr[7] || bus_req !== 1'b1) begin
                n_fail++;
                $display("FAIL %s bus cmd: req=%b we=%b addr=%h, required req=1 we=%b addr=%h",
                         name, bus_req, bus_we, bus_addr, hdr[7], exp_addr);
            end
        end
        wait_resp(name, 1, 0, exp_lat, exp_req);
        @(negedge clk);
        n_checks++;
        if (tx_load !== 1'b0 || busy !== 1'b0 || tx_data !== exp_resp) begin
            n_fail++;
            $display("FAIL %s after resp: tx_load=%b busy=%b tx_data=%h, required 0 0 %h",
                     name, tx_load, busy, tx_data, exp_resp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx_data !== '0 || tx_load !== 1'b0 || bus_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset ctl: tx_data=%h tx_load=%b bus_req=%b busy=%b, required all 0",
                     tx_data, tx_load, bus_req, busy);
        end
        n_checks++;
        if (bus_we !== 1'b0 || bus_addr !== 6'd0 || bus_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset bus: we=%b addr=%h wdata=%h, required all 0", bus_we, bus_addr, bus_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        n_checks++;
        xact("write", 8'h85, 32'h1234_5678, 3, 32'hFFFF_FFFF, 6'd5, {8'h85, 32'h1234_5678}, 4, 3);
        if (bus_wdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL write wdata: got %h, required 12345678", bus_wdata);
        end
    endtask

    task automatic test_ptr_read();
        xact("ptr_read1", 8'h55, 32'h0, 1, 32'hA, 6'd6, {8'h86, 32'hA}, 2, 1);
        xact("ptr_read2", 8'h7F, 32'h0, 1, 32'hB, 6'd7, {8'h87, 32'hB}, 2, 1);
    endtask

    task automatic test_nop();
        xact("nop", 8'h3F, 32'hDEAD_BEEF, 1, 32'h1, 6'd0, {8'h9F, 32'h0}, 1, 0);
        xact("ptr_after_nop", 8'h40, 32'h0, 1, 32'hC, 6'd8, {8'h88, 32'hC}, 2, 1);
    endtask

    task automatic test_timeout();
        xact("timeout", 8'h12, 32'h0, 0, 32'h0, 6'h12, {8'hD2, 32'h0}, TIMEOUT + 1, TIMEOUT);
        xact("after_timeout", 8'h03, 32'h0, 1, 32'h33, 6'h03, {8'h83, 32'h33}, 2, 1);
        xact("ack_at_expiry", 8'h04, 32'h0, TIMEOUT, 32'h44, 6'h04, {8'h84, 32'h44}, TIMEOUT + 1, TIMEOUT);
    endtask

    task automatic test_overrun();
        // Second packet during ACCESS: dropped, reported in current response.
        ack_delay = 3;
        rdata_val = 32'h55;
        exp_q.push_back({8'hAA, 32'h55});
        send(8'h0A, 32'h0);
        n_checks++;
        if (bus_req !== 1'b1 || bus_addr !== 6'h0A) begin
            n_fail++;
            $display("FAIL overrun cmd: req=%b addr=%h, required 1 0a", bus_req, bus_addr);
        end
        send(8'h81, 32'hFFFF);
        wait_resp("overrun_access", 2, 1, 4, 3);
        @(negedge clk);
        xact("after_overrun", 8'h0B, 32'h0, 1, 32'h66, 6'h0B, {8'h8B, 32'h66}, 2, 1);
        // Pointer must be untouched by the dropped write to address 1.
        xact("ptr_after_drop", 8'h40, 32'h0, 1, 32'h77, 6'h0C, {8'h8C, 32'h77}, 2, 1);
        // Packet in the RESP cycle: reported in the following response.
        ack_delay = 1;
        rdata_val = 32'h1;
        exp_q.push_back({8'h8D, 32'h1});
        send(8'h0D, 32'h0);
        wait_resp("resp_cycle_base", 1, 0, 2, 1);
        send(8'h01, 32'h0);
        xact("overrun_resp", 8'h0E, 32'h0, 1, 32'h2, 6'h0E, {8'hAE, 32'h2}, 2, 1);
    endtask

    task automatic test_reset_mid();
        int loads;
        ack_delay = 0;
        send(8'h88, 32'hCAFE);
        n_checks++;
        if (bus_req !== 1'b1 || bus_addr !== 6'h08 || bus_we !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid cmd: req=%b addr=%h we=%b, required 1 08 1", bus_req, bus_addr, bus_we);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_req !== 1'b0 || busy !== 1'b0 || tx_load !== 1'b0 || bus_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: req=%b busy=%b tx_load=%b addr=%h, required 0 0 0 00",
                     bus_req, busy, tx_load, bus_addr);
        end
        rst = 1'b0;
        loads = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_load === 1'b1) loads++;
            @(negedge clk);
        end
        n_checks++;
        if (loads !== 0) begin
            n_fail++;
            $display("FAIL reset_mid tx_load: got %0d loads, required 0", loads);
        end
        xact("ptr_after_reset", 8'h40, 32'h0, 1, 32'h99, 6'd0, {8'h80, 32'h99}, 2, 1);
    endtask

    initial begin
        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        @(negedge clk);
        test_reset();
        test_write();
        test_ptr_read();
        test_nop();
        test_timeout();
        test_overrun();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
